// File: rtl/l3_req_arbiter_if.sv
// rtl/l3_req_arbiter_if.sv - requester-side and L3-side handshake bundle for the L3 request arbiter
interface l3_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 56,
    parameter int LINE_SIZE  = 128
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LINE_SIZE-1:0]  req_wdata;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            req_err;
    logic [LINE_SIZE-1:0]          req_rdata;

    logic                          l3_req;
    logic                          l3_we;
    logic [ADDR_WIDTH-1:0]         l3_addr;
    logic [LINE_SIZE-1:0]          l3_wdata;
    logic [LINE_SIZE-1:0]          l3_rdata;
    logic                          l3_ack;

    // master: the arbiter itself; slave: the requesters plus the L3 controller
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, l3_rdata, l3_ack,
        output req_ack, req_err, req_rdata, l3_req, l3_we, l3_addr, l3_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, l3_rdata, l3_ack,
        input  req_ack, req_err, req_rdata, l3_req, l3_we, l3_addr, l3_wdata
    );
endinterface

// File: rtl/l3_req_arbiter.sv
// rtl/l3_req_arbiter.sv - round-robin sequencer sharing one L3 port among NUM_REQ requesters, with watchdog
module l3_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 56,
    parameter int LINE_SIZE  = 128,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    l3_req_arbiter_if.master   bus,
    output logic               busy,
    output logic [31:0]        timeout_count
);
    localparam int          IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [IDW-1:0]         rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]         id, id_nxt, id_inc;
    logic [31:0]            timer, timer_nxt, to_cnt_nxt;
    logic                   l3_req_nxt, l3_we_nxt;
    logic [ADDR_WIDTH-1:0]  l3_addr_nxt;
    logic [LINE_SIZE-1:0]   l3_wdata_nxt, rdata_nxt;
    logic [NUM_REQ-1:0]     ack_nxt, err_nxt;
    logic                   win_found;
    logic [IDW-1:0]         win_id;
    logic                   expire;

    assign id_inc = (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
    assign expire = WD_EN && (timer == TO_LAST);

    // Scan downwards so the requester closest to rr_ptr is the last one written, i.e. it wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_w;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = IDW'(idx);
            if (bus.req_valid[idx_w]) begin
                win_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id            <= '0;
            timer         <= '0;
            timeout_count <= '0;
            busy          <= 1'b0;
            bus.l3_req    <= 1'b0;
            bus.l3_we     <= 1'b0;
            bus.l3_addr   <= '0;
            bus.l3_wdata  <= '0;
            bus.req_ack   <= '0;
            bus.req_err   <= '0;
            bus.req_rdata <= '0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            id            <= id_nxt;
            timer         <= timer_nxt;
            timeout_count <= to_cnt_nxt;
            busy          <= (state_nxt != IDLE);
            bus.l3_req    <= l3_req_nxt;
            bus.l3_we     <= l3_we_nxt;
            bus.l3_addr   <= l3_addr_nxt;
            bus.l3_wdata  <= l3_wdata_nxt;
            bus.req_ack   <= ack_nxt;
            bus.req_err   <= err_nxt;
            bus.req_rdata <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = BUSY;
            BUSY: begin
                if (bus.l3_ack)  state_nxt = RESP;
                else if (expire) state_nxt = DRAIN;
            end
            RESP:    state_nxt = IDLE;
            DRAIN:   if (bus.l3_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack beats the watchdog when both land on the same cycle; a late ack in DRAIN is simply dropped.
    always_comb begin
        rr_ptr_nxt   = rr_ptr;
        id_nxt       = id;
        timer_nxt    = timer;
        to_cnt_nxt   = timeout_count;
        l3_req_nxt   = bus.l3_req;
        l3_we_nxt    = bus.l3_we;
        l3_addr_nxt  = bus.l3_addr;
        l3_wdata_nxt = bus.l3_wdata;
        rdata_nxt    = bus.req_rdata;
        ack_nxt      = '0;
        err_nxt      = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    id_nxt       = win_id;
                    l3_req_nxt   = 1'b1;
                    l3_we_nxt    = bus.req_we[win_id];
                    l3_addr_nxt  = bus.req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    l3_wdata_nxt = bus.req_wdata[int'(win_id)*LINE_SIZE +: LINE_SIZE];
                    timer_nxt    = '0;
                end
            end
            BUSY: begin
                if (bus.l3_ack) begin
                    l3_req_nxt  = 1'b0;
                    ack_nxt[id] = 1'b1;
                    rdata_nxt   = bus.l3_rdata;
                    rr_ptr_nxt  = id_inc;
                end else if (expire) begin
                    l3_req_nxt  = 1'b0;
                    ack_nxt[id] = 1'b1;
                    err_nxt[id] = 1'b1;
                    rdata_nxt   = '0;
                    to_cnt_nxt  = timeout_count + 32'd1;
                    rr_ptr_nxt  = id_inc;
                end else begin
                    timer_nxt   = timer + 32'd1;
                end
            end
            default: ;
        endcase
    end
endmodule
